// File: rtl/parity_pkg.sv
// Shared definitions for the parity encoder/decoder pair: skid-buffer state
// encoding, default payload width and the even-parity helper.
package parity_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int PAR_MAX_WIDTH  = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // Callers zero-extend narrower payloads; padding zeros leave the XOR unchanged.
    function automatic logic parity_calc(input logic [PAR_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/parity_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready/out_valid;
// out_data comes straight from the main register.
module parity_skid_buf
    import parity_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state;
    skid_state_t      next_state;
    logic [WIDTH-1:0] skid;
    logic             accept;
    logic             send;

    always_comb begin
        accept     = in_valid && in_ready;
        send       = out_valid && out_ready;
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_ONE;
            ST_ONE: begin
                if (accept && !send)      next_state = ST_TWO;
                else if (send && !accept) next_state = ST_EMPTY;
            end
            ST_TWO:   if (send) next_state = ST_ONE;
            default:  next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != ST_EMPTY);
            in_ready  <= (next_state != ST_TWO);
            case (state)
                ST_EMPTY: if (accept) out_data <= in_data;
                ST_ONE: begin
                    if (accept && send) out_data <= in_data;
                    else if (accept)    skid     <= in_data;
                end
                ST_TWO:   if (send) out_data <= skid;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/parity_encoder.sv
// Even-parity encoder: {parity, byte} words through a 2-entry skid buffer,
// plus a wrapping sent-word counter. PARITY_ENC_ERR_INJECT_EN adds error injection.
module parity_encoder
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_data,
    output logic [CNT_WIDTH-1:0]  sent_cnt
`ifdef PARITY_ENC_ERR_INJECT_EN
    ,
    input  logic                  inject_err,
    output logic [CNT_WIDTH-1:0]  inj_cnt
`endif
);

    logic [PAR_MAX_WIDTH-1:0] in_ext;
    logic                     par_bit;
    logic                     send;

    always_comb begin
        in_ext                 = '0;
        in_ext[DATA_WIDTH-1:0] = in_byte;
`ifdef PARITY_ENC_ERR_INJECT_EN
        par_bit = parity_calc(in_ext) ^ inject_err;
`else
        par_bit = parity_calc(in_ext);
`endif
        send = out_valid && out_ready;
    end

    parity_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({par_bit, in_byte}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always_ff @(posedge clk) begin
        if (arst) sent_cnt <= '0;
        else if (send) sent_cnt <= sent_cnt + CNT_WIDTH'(1);
    end

`ifdef PARITY_ENC_ERR_INJECT_EN
    // An injected word is recognised at send time by its odd overall parity.
    logic [PAR_MAX_WIDTH-1:0] out_ext;
    logic                     out_bad;

    always_comb begin
        out_ext                 = '0;
        out_ext[DATA_WIDTH-1:0] = out_data[DATA_WIDTH-1:0];
        out_bad                 = out_data[DATA_WIDTH] != parity_calc(out_ext);
    end

    always_ff @(posedge clk) begin
        if (arst) inj_cnt <= '0;
        else if (send && out_bad) inj_cnt <= inj_cnt + CNT_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_parity_encoder.sv
// Self-checking bench for parity_encoder against a queue-based model
// (works with or without PARITY_ENC_ERR_INJECT_EN defined).
module tb_parity_encoder;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_data;
    logic [15:0] sent_cnt;
`ifdef PARITY_ENC_ERR_INJECT_EN
    logic        inject_err = 1'b0;
    logic [15:0] inj_cnt;
`endif

    int unsigned compared = 0;
    int unsigned failed   = 0;

    logic [8:0]  exp_q[$];
    logic        exp_inj_q[$];
    logic [15:0] exp_cnt = '0;
    logic [15:0] exp_inj_cnt = '0;

    always #5 clk = ~clk;

    parity_encoder #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sent_cnt  (sent_cnt)
`ifdef PARITY_ENC_ERR_INJECT_EN
        ,
        .inject_err (inject_err),
        .inj_cnt    (inj_cnt)
`endif
    );

    // One clock of stimulus; model: FIFO of depth 2, word = {even parity ^ inject, byte}.
    task automatic step(input logic v, input logic [7:0] b, input logic r, input logic inj);
        logic acc, snd, inj_eff;
`ifdef PARITY_ENC_ERR_INJECT_EN
        inj_eff = inj;
        inject_err = inj;
`else
        inj_eff = 1'b0;
`endif
        acc = v && (exp_q.size() < 2);
        snd = r && (exp_q.size() > 0);
        in_valid = v;
        in_byte = b;
        out_ready = r;
        @(posedge clk);
        #1;
        if (snd) begin
            void'(exp_q.pop_front());
            if (exp_inj_q.pop_front()) exp_inj_cnt = exp_inj_cnt + 16'd1;
            exp_cnt = exp_cnt + 16'd1;
        end
        if (acc) begin
            exp_q.push_back({(^b) ^ inj_eff, b});
            exp_inj_q.push_back(inj_eff);
        end
    endtask

    task automatic do_reset(input logic v, input logic r);
        arst = 1'b1;
        in_valid = v;
        out_ready = r;
        in_byte = 8'hEE;
        @(posedge clk);
        #1;
        arst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        exp_inj_q.delete();
        exp_cnt = '0;
        exp_inj_cnt = '0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        compared++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++;
        if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        compared++;
        if (out_data !== 9'h000) begin failed++; $display("FAIL reset_out_data: got %h want 000", out_data); end
        compared++;
        if (sent_cnt !== 16'h0000) begin failed++; $display("FAIL reset_sent_cnt: got %h want 0000", sent_cnt); end
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        compared++;
        if (out_valid !== 1'b1) begin failed++; $display("FAIL single_valid: got %b want 1", out_valid); end
        compared++;
        if (out_data !== 9'h0A5) begin failed++; $display("FAIL single_data: got %h want 0a5", out_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        compared++;
        if (sent_cnt !== 16'd1) begin failed++; $display("FAIL single_cnt: got %0d want 1", sent_cnt); end
        compared++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL single_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'h01, 1'b1, 1'b0);
        compared++;
        if (out_data !== 9'h101 || in_ready !== 1'b1) begin
            failed++; $display("FAIL b2b_first: got data %h rdy %b want 101 rdy 1", out_data, in_ready);
        end
        step(1'b1, 8'h03, 1'b1, 1'b0);
        compared++;
        if (out_data !== 9'h003 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failed++; $display("FAIL b2b_second: got data %h rdy %b vld %b want 003 1 1", out_data, in_ready, out_valid);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        compared++;
        if (sent_cnt !== exp_cnt) begin failed++; $display("FAIL b2b_cnt: got %0d want %0d", sent_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [8:0] want[3];
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        compared++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        step(1'b1, 8'h30, 1'b0, 1'b0);
        compared++;
        if (out_data !== 9'h110 || out_valid !== 1'b1) begin
            failed++; $display("FAIL bp_hold: got data %h vld %b want 110 1", out_data, out_valid);
        end
        want[0] = 9'h110; want[1] = 9'h120; want[2] = 9'h030;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (out_valid !== 1'b1 || out_data !== want[i]) begin
                failed++; $display("FAIL bp_drain%0d: got vld %b data %h want 1 %h", i, out_valid, out_data, want[i]);
            end
            step(i < 2, 8'h30, 1'b1, 1'b0);
        end
        compared++;
        if (out_valid !== 1'b0 || sent_cnt !== exp_cnt) begin
            failed++; $display("FAIL bp_end: got vld %b cnt %0d want 0 %0d", out_valid, sent_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sent_cnt !== 16'h0000) begin
            failed++; $display("FAIL mid_reset: got vld %b rdy %b cnt %h want 0 1 0000", out_valid, in_ready, sent_cnt);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        compared++;
        if (out_valid !== 1'b0 || sent_cnt !== 16'h0000) begin
            failed++; $display("FAIL mid_stale: got vld %b cnt %h want 0 0000", out_valid, sent_cnt);
        end
    endtask

    task automatic test_wrap();
        int unsigned guard = 0;
        while (exp_cnt != 16'hFFFF && guard < 70000) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            guard++;
        end
        compared++;
        if (sent_cnt !== 16'hFFFF) begin failed++; $display("FAIL wrap_max: got %h want ffff", sent_cnt); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        compared++;
        if (sent_cnt !== 16'h0000) begin failed++; $display("FAIL wrap_zero: got %h want 0000", sent_cnt); end
    endtask

    task automatic test_inject();
        do_reset(1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b0, 1'b1);
`ifdef PARITY_ENC_ERR_INJECT_EN
        compared++;
        if (out_data !== 9'h007) begin failed++; $display("FAIL inj_data: got %h want 007", out_data); end
        compared++;
        if ((^out_data) !== 1'b1) begin failed++; $display("FAIL inj_decoder_err: got %b want 1", ^out_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        compared++;
        if (inj_cnt !== 16'd1) begin failed++; $display("FAIL inj_cnt: got %0d want 1", inj_cnt); end
`else
        compared++;
        if (out_data !== 9'h107) begin failed++; $display("FAIL inj_off_data: got %h want 107", out_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_random();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            compared++;
            if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < 2)) begin
                failed++; $display("FAIL rnd_flags@%0d: got vld %b rdy %b want %b %b", i, out_valid, in_ready,
                                   exp_q.size() != 0, exp_q.size() < 2);
            end
            if (exp_q.size() != 0) begin
                compared++;
                if (out_data !== exp_q[0]) begin failed++; $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, exp_q[0]); end
            end
            compared++;
            if (sent_cnt !== exp_cnt) begin failed++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, sent_cnt, exp_cnt); end
`ifdef PARITY_ENC_ERR_INJECT_EN
            compared++;
            if (inj_cnt !== exp_inj_cnt) begin failed++; $display("FAIL rnd_inj@%0d: got %0d want %0d", i, inj_cnt, exp_inj_cnt); end
`endif
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_inject();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/parity_encoder.md
Name: parity_encoder

Overview:
- Transmit-side counterpart of the parity decoder. Takes DATA_WIDTH-bit bytes over a valid/ready handshake and emits (DATA_WIDTH+1)-bit words on a second valid/ready handshake.
- Each output word is the byte in bits [DATA_WIDTH-1:0] plus an even-parity bit in bit [DATA_WIDTH]. The XOR of all DATA_WIDTH+1 bits of a correct word is therefore 0, which is the condition the decoder checks.
- A 2-entry skid buffer provides full throughput while keeping in_ready registered.
- A wrapping sent-word counter supports link monitoring.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- CNT_WIDTH, 16, width of the sent-word counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- arst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  encoder can accept; registered.
- in_byte  input  DATA_WIDTH  payload byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DATA_WIDTH+1  {parity, byte}.
- sent_cnt  output  CNT_WIDTH  number of completed output transfers, modulo 2^CNT_WIDTH.

Behaviour:
- Handshake events:
  - Accept: in_valid && in_ready at a rising edge.
  - Send: out_valid && out_ready at a rising edge.
- Parity: parity = XOR of in_byte bits. It is computed at accept and stored with the byte; it is never recomputed at output.
- Storage:
  - Main register drives out_data.
  - Skid register holds one extra word.
  - State EMPTY / ONE / TWO = number of words held.
- Reset (arst high at an edge):
  - state = EMPTY, out_valid = 0, in_ready = 1, out_data = 0, sent_cnt = 0.
  - Reset asserted mid-operation discards all held words with no send.
  - Reset takes priority over every other event in that cycle.
- Outputs by state: out_valid = (state != EMPTY); in_ready = (state != TWO), registered from next-state.
- Transitions:
  - EMPTY:
    - Accept → ONE; main register loaded.
  - ONE:
    - Accept without send → TWO; word goes into the skid register.
    - Send without accept → EMPTY.
    - Accept with send → ONE; main register reloaded with the new word.
    - Neither → hold.
  - TWO (no accept possible):
    - Send → ONE; skid register moves to main.
    - Otherwise hold.
- Latency: a word accepted at edge N is presented with out_valid at N+1.
- Throughput: one word per cycle when out_ready is held high.
- Stability: while out_valid && !out_ready, out_data is held bit-stable. Words are never dropped, duplicated or reordered.
- in_byte is ignored whenever in_ready = 0.
- sent_cnt:
  - Increments by 1 on every send.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Unaffected by accepts.

Optional Feature:
- Macro: PARITY_ENC_ERR_INJECT_EN.
- When defined:
  - Adds input port inject_err (1 bit).
  - If inject_err = 1 at accept, the stored parity bit is inverted. That word then fails the decoder's check; the payload bits are unchanged.
  - Adds output port inj_cnt (CNT_WIDTH bits), counting sends of injected words. It resets to 0 and wraps.
- When undefined:
  - Neither port exists.
  - Parity is always correct.
  - Logic is identical to the base behaviour.

Decomposition:
- Shared package parity_pkg holds:
  - State encoding constants: ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2.
  - Default DATA_WIDTH.
  - Function parity_calc(byte) returning the XOR reduction. The decoder reuses the same function for its check.
- One sub-module is natural: parity_skid_buf. It is a generic 2-entry valid/ready buffer parameterised on word width. The top level computes parity, instantiates the buffer with width DATA_WIDTH+1, and owns the counters.

Test Plan:
- Reset, then accept 0xA5 with out_ready = 1 → next cycle out_valid = 1, out_data = 9'h0A5 (parity 0), sent_cnt = 1 after the send.
- Accept 0x01, then 0x03 back-to-back with out_ready = 1 → out_data 9'h101 then 9'h003, one per cycle, in_ready stays 1.
- out_ready = 0, offer 0x10, 0x20, 0x30 → first two accepted, in_ready = 0 on the cycle after the second accept, out_data held at 9'h110. Raise out_ready → 9'h110, 9'h120, 9'h030 in order, no loss.
- Fill to TWO, assert arst for one cycle → out_valid = 0, in_ready = 1, sent_cnt = 0 next cycle; stale words never appear.
- Force sent_cnt to 0xFFFF (CNT_WIDTH = 16), complete one send → sent_cnt = 0x0000.
- With PARITY_ENC_ERR_INJECT_EN defined: accept 0x07 with inject_err = 1 → out_data 9'h007 (parity inverted from 1), decoder reports err = 1, inj_cnt = 1. Without the macro, the same stimulus gives 9'h107.
